beat_pulse_gen: RTL and testbench
=================================

# beat_pulse_gen

Beat-event producer for the spectral-flux path. It consumes one unsigned spectral-flux sample per analysis frame and tracks a running average with an exponential moving average. When a frame's flux clearly exceeds that adaptive threshold, it emits a single-cycle `beat` strobe. It sits between the flux computation stage and the beat consumers (drum trigger and beat counter), and it owns the refractory interval, so downstream logic can treat every `beat` as a distinct event.

## Interface
- `FLUX_W`, 16: width of the flux sample.
- `ALPHA_SHIFT`, 3: EMA smoothing shift; weight of the new sample is 1/2^ALPHA_SHIFT.
- `THR_SHIFT`, 1: threshold margin is avg >> THR_SHIFT.
- `MIN_FLUX`, 64: absolute floor added to the threshold.
- `HOLDOFF`, 4000000: refractory length after a beat, in clk cycles, ≥ 2.
- `WARMUP`, 8: number of initial frames after reset during which beats are suppressed.
- `PULSE_LEN`, 2500000: stretched pulse length in cycles; used only with the macro below.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `flux_valid`  in  1  single-cycle strobe; `flux` is valid this cycle.
- `flux`  in  FLUX_W  unsigned spectral flux of the current frame.
- `beat`  out  1  single-cycle beat strobe, registered.
- `beat_count`  out  4  beats modulo 10 (0..9).
- `avg_flux`  out  FLUX_W  current EMA value, acc >> ALPHA_SHIFT.
- `armed`  out  1  high when state is ARMED and warm-up is complete.

## Operation
- **Accumulator.** `acc` is FLUX_W+ALPHA_SHIFT bits wide and unsigned. On each `flux_valid`: acc ← acc − (acc >> ALPHA_SHIFT) + flux. No overflow is possible at this width. The update happens in every state.
- **Threshold.**
  - thr = avg + (avg >> THR_SHIFT) + MIN_FLUX, computed in FLUX_W+2 bits with no saturation.
  - avg is the value before the current sample's update.
  - The comparison is strict: flux > thr. Equality does not produce a beat.
- **Warm-up.**
  - `frame_cnt` counts `flux_valid` strobes and saturates at WARMUP.
  - A frame is eligible only if frame_cnt == WARMUP before that strobe. Frames 1..WARMUP can never fire.
- **State machine (ARMED, HOLD).**
  - In ARMED, an eligible `flux_valid` with flux > thr causes:
    - `beat` = 1 on the next cycle;
    - transition to HOLD;
    - `hold_cnt` loaded with HOLDOFF−1;
    - `beat_count` incremented, wrapping 9→0.
  - In HOLD: if hold_cnt != 0, hold_cnt decrements; if hold_cnt == 0, the next state is ARMED. `flux_valid` in HOLD updates `acc` and `frame_cnt` only.
- **Simultaneous events.** When the HOLD→ARMED transition coincides with `flux_valid`, that frame is evaluated as HOLD and cannot fire.
- **Reset values.**
  - Outputs: `beat`=0, `beat_count`=0, `avg_flux`=0, `armed`=0.
  - Internal: acc=0, frame_cnt=0, hold_cnt=0, state ARMED.
- **Reset mid-HOLD.** Aborts the refractory interval immediately and restarts warm-up.

## Timing
- **Latency.** `flux_valid` at cycle N produces `beat` at cycle N+1, high for exactly one cycle.
- **Average update.** `avg_flux` reflects sample N at cycle N+1.
- **Refractory window.** For a beat at cycle B:
  - the state is HOLD from cycle B through B+HOLDOFF−1;
  - the state is ARMED at B+HOLDOFF;
  - the earliest next beat is at B+HOLDOFF+1.
- **Throughput.** Back-to-back `flux_valid` strobes (every cycle) are legal.
- **armed output.** Registered; combines state == ARMED and warm-up complete.

## Configuration
- `BEAT_PULSE_GEN_STRETCH_EN`
- **Defined:**
  - `beat` becomes a level held high for PULSE_LEN cycles, starting at cycle N+1, using a dedicated down-counter.
  - A new beat inside the stretch window (possible only if HOLDOFF < PULSE_LEN) reloads the counter.
  - Reset clears the stretch counter.
- **Undefined:** `beat` is the single-cycle strobe described above, and no stretch counter is synthesized.

## Test plan
All scenarios use HOLDOFF=16 and WARMUP=8.
- **Warm-up suppression.** Apply reset, then 8 frames of flux=1000. Require `beat` = 0 throughout and `armed` = 1 only after the 8th frame.
- **Steady state and detection.**
  - Stimulus: 64 frames of flux=100, then one frame of flux=400.
  - Require `avg_flux` in 98..100 before the 400 frame.
  - Require thr ≈ 214, so `beat` = 1 exactly one cycle after the 400 strobe and `beat_count` = 1.
- **Threshold equality.** Drive flux exactly equal to the computed thr, then thr+1. Require no beat for the equal sample and a beat for thr+1.
- **Refractory boundary.**
  - Stimulus: beat at cycle B, then flux=400 at B+5, at B+15, and at B+16.
  - Require no beat from the B+5 or B+15 samples.
  - Require a beat at B+17 from the B+16 sample.
- **Count wrap.** Produce 10 spaced beats. Require `beat_count` 1..9 and then 0 after the 10th beat.
- **Reset mid-HOLD.** Assert `rst` at B+3. Require all outputs at their reset values immediately, and no beats for the next 8 frames.

Source files
------------

// File: rtl/beat_pulse_gen.sv
// Spectral-flux beat detector: EMA-based adaptive threshold, warm-up gating and a refractory hold.
// Define BEAT_PULSE_GEN_STRETCH_EN to stretch `beat` into a PULSE_LEN-cycle level.
module beat_pulse_gen #(
  parameter int FLUX_W      = 16,
  parameter int ALPHA_SHIFT = 3,
  parameter int THR_SHIFT   = 1,
  parameter int MIN_FLUX    = 64,
  parameter int HOLDOFF     = 4000000,
  parameter int WARMUP      = 8,
  parameter int PULSE_LEN   = 2500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flux_valid,
  input  logic [FLUX_W-1:0] flux,
  output logic              beat,
  output logic [3:0]        beat_count,
  output logic [FLUX_W-1:0] avg_flux,
  output logic              armed
);

  localparam int AW = FLUX_W + ALPHA_SHIFT;
  localparam int TW = FLUX_W + 2;
  localparam int HW = $clog2(HOLDOFF);
  localparam int FW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF - 1);
  localparam logic [FW-1:0] WARM_DONE = FW'(WARMUP);

  typedef enum logic {ARMED = 1'b0, HOLD = 1'b1} state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_nxt;
  logic [FW-1:0] frame_cnt;
  logic [FW-1:0] frame_nxt;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] thr;
  logic          warm;
  logic          above;
  logic          fire;

  // Threshold uses the average from before this frame's update.
  assign avg_flux  = acc[AW-1:ALPHA_SHIFT];
  assign thr       = TW'(avg_flux) + TW'(avg_flux >> THR_SHIFT) + TW'(MIN_FLUX);
  assign above     = {2'b00, flux} > thr;
  assign acc_nxt   = acc - (acc >> ALPHA_SHIFT) + AW'(flux);
  assign warm      = (frame_cnt == WARM_DONE);
  assign frame_nxt = (flux_valid && !warm) ? frame_cnt + FW'(1) : frame_cnt;
  assign fire      = flux_valid && (state == ARMED) && warm && above;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      frame_cnt <= '0;
    end else if (flux_valid) begin
      acc       <= acc_nxt;
      frame_cnt <= frame_nxt;
    end
  end

  // armed is registered from the next-state values so it tracks the state it reports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARMED;
      hold_cnt   <= '0;
      armed      <= 1'b0;
      beat_count <= 4'd0;
    end else begin
      case (state)
        ARMED: begin
          if (fire) begin
            state      <= HOLD;
            hold_cnt   <= HOLD_INIT;
            armed      <= 1'b0;
            beat_count <= (beat_count == 4'd9) ? 4'd0 : beat_count + 4'd1;
          end else begin
            armed <= (frame_nxt == WARM_DONE);
          end
        end
        HOLD: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
            armed    <= 1'b0;
          end else begin
            state <= ARMED;
            armed <= (frame_nxt == WARM_DONE);
          end
        end
        default: begin
          state <= ARMED;
          armed <= 1'b0;
        end
      endcase
    end
  end

`ifdef BEAT_PULSE_GEN_STRETCH_EN
  localparam int PW = (PULSE_LEN < 2) ? 1 : $clog2(PULSE_LEN);
  localparam logic [PW-1:0] PULSE_INIT = PW'(PULSE_LEN - 1);

  logic [PW-1:0] pulse_cnt;

  // A fresh beat reloads the window even if a pulse is still running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_cnt <= '0;
      beat      <= 1'b0;
    end else if (fire) begin
      pulse_cnt <= PULSE_INIT;
      beat      <= 1'b1;
    end else begin
      beat <= (pulse_cnt != '0);
      if (pulse_cnt != '0) pulse_cnt <= pulse_cnt - PW'(1);
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) beat <= 1'b0;
    else     beat <= fire;
  end
`endif

endmodule

// File: tb/tb_beat_pulse_gen.sv
// Directed bench for beat_pulse_gen; a cycle-indexed arithmetic model is checked against the DUT every cycle.
module tb_beat_pulse_gen;
  localparam int HOLDOFF = 16;
  localparam int WARMUP  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flux_valid = 1'b0;
  logic [15:0] flux = '0;
  logic        beat;
  logic [3:0]  beat_count;
  logic [15:0] avg_flux;
  logic        armed;

  beat_pulse_gen #(.HOLDOFF(HOLDOFF), .WARMUP(WARMUP)) dut (
    .clk(clk), .rst(rst), .flux_valid(flux_valid), .flux(flux),
    .beat(beat), .beat_count(beat_count), .avg_flux(avg_flux), .armed(armed)
  );

  always #5 clk = ~clk;

  int     tests = 0;
  int     fails = 0;
  bit     started = 0;
  longint m_acc, cyc, armed_at, m_thr_last;
  int     m_frames, m_count;
  bit     exp_beat, exp_armed;

  task automatic check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_frames = 0; m_count = 0; armed_at = 0;
    exp_beat = 0; exp_armed = 0;
  endtask

  // Present one cycle of input, then advance the model to the cycle after the edge.
  task automatic step(bit v, int f);
    longint avg, thr;
    flux_valid = v;
    flux = 16'(f);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      exp_beat = 0;
      if (v) begin
        avg = m_acc / 8;
        thr = avg + avg / 2 + 64;
        m_thr_last = thr;
        if (m_frames == WARMUP && cyc >= armed_at && f > thr) begin
          exp_beat = 1;
          armed_at = cyc + 1 + HOLDOFF;
          m_count = (m_count + 1) % 10;
        end
        m_acc = m_acc - m_acc / 8 + f;
        if (m_frames < WARMUP) m_frames++;
      end
    end
    cyc++;
    exp_armed = !rst && m_frames == WARMUP && cyc >= armed_at;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    step(0, 0);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("beat", beat, exp_beat);
      check("beat_count", beat_count, m_count);
      check("avg_flux", avg_flux, m_acc / 8);
      check("armed", armed, exp_armed);
    end
  end

  initial begin
    cyc = 0;
    model_reset();
    step(0, 0);
    step(0, 0);
    started = 1;
    check("rst_beat", beat, 0);
    check("rst_count", beat_count, 0);
    check("rst_avg", avg_flux, 0);
    check("rst_armed", armed, 0);
    rst = 1'b0;

    // Warm-up: large flux must not fire during the first WARMUP frames.
    for (int i = 0; i < WARMUP; i++) begin
      step(1, 1000);
      check("warm_beat", beat, 0);
      check("warm_armed", armed, (i == WARMUP - 1) ? 1 : 0);
    end

    // Steady state then detection.
    do_reset();
    repeat (64) step(1, 100);
    check("steady_avg_range", (avg_flux >= 98 && avg_flux <= 100) ? 1 : 0, 1);
    check("steady_model_avg", m_acc / 8, 100);
    check("steady_no_beat", beat_count, 0);
    step(1, 400);
    check("model_thr", m_thr_last, 214);
    check("detect_beat", beat, 1);
    check("detect_count", beat_count, 1);
    step(0, 0);
    check("detect_one_cycle", beat, 0);

    // Threshold equality is not a beat; one above is.
    do_reset();
    repeat (64) step(1, 100);
    step(1, 214);
    check("eq_beat", beat, 0);
    repeat (64) step(1, 100);
    check("eq_resettle_avg", avg_flux, 100);
    step(1, 215);
    check("eq1_beat", beat, 1);

    // Refractory boundary relative to beat cycle B (now in cycle B).
    repeat (5) step(0, 0);
    step(1, 400);
    check("hold_b5", beat, 0);
    repeat (9) step(0, 0);
    step(1, 400);
    check("hold_b15", beat, 0);
    step(1, 400);
    check("hold_b16", beat, 1);
    check("hold_count", beat_count, 2);

    // Count wrap over 10 spaced beats.
    do_reset();
    repeat (64) step(1, 100);
    for (int i = 0; i < 10; i++) begin
      step(1, 400);
      check("wrap_beat", beat, 1);
      check("wrap_count", beat_count, (i + 1) % 10);
      repeat (20) step(1, 100);
    end

    // Reset in the middle of HOLD.
    step(1, 400);
    check("mid_beat", beat, 1);
    check("mid_count", beat_count, 1);
    repeat (3) step(0, 0);
    rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_beat", beat, 0);
    check("mid_rst_count", beat_count, 0);
    check("mid_rst_avg", avg_flux, 0);
    check("mid_rst_armed", armed, 0);
    step(0, 0);
    rst = 1'b0;
    for (int i = 0; i < WARMUP; i++) begin
      step(1, 1000);
      check("mid_warm_beat", beat, 0);
    end
    check("mid_warm_armed", armed, 1);
    step(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
